// File: rtl/prbs8_checker.sv
// PRBS8 checker: self-synchronising receiver for x[n] = x[n-2]^x[n-3]^x[n-4]^x[n-8].
// The checker seeds its 8-bit history from the stream and then tracks until
// LOCK_CNT consecutive matches are seen. While locked, a leaky bucket of
// mismatches forces a resync. Mismatches seen while locked are reported by
// the err pulse and counted in err_cnt.
module prbs8_checker #(
  parameter int unsigned LOCK_CNT   = 16,
  parameter int unsigned UNLOCK_CNT = 8,
  parameter int unsigned ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [4:0] LOCK_N   = 5'(LOCK_CNT);
  localparam logic [4:0] UNLOCK_N = 5'(UNLOCK_CNT);

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [7:0]       h, h_nxt, h_shift;
  logic [2:0]       seed_cnt, seed_cnt_nxt;
  logic [4:0]       good_cnt, good_cnt_nxt;
  logic [4:0]       bad_cnt, bad_cnt_nxt;
  logic             exp_bit, match, h_zero;
  logic             locked_nxt, err_nxt;
  logic [ERR_W-1:0] err_cnt_nxt;

  // Prediction uses the history before the new bit is shifted in
  assign exp_bit = h[1] ^ h[2] ^ h[3] ^ h[7];
  assign match   = (in_bit == exp_bit);
  assign h_shift = {h[6:0], in_bit};
  assign h_zero  = (h_shift == 8'h00);
  assign h_nxt   = in_valid ? h_shift : h;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SEED;
    else        state <= state_nxt;
  end

  // History and lock/unlock counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h        <= '0;
      seed_cnt <= '0;
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else begin
      h        <= h_nxt;
      seed_cnt <= seed_cnt_nxt;
      good_cnt <= good_cnt_nxt;
      bad_cnt  <= bad_cnt_nxt;
    end
  end

  // Next-state and counter update; nothing moves without a valid bit
  always_comb begin
    state_nxt    = state;
    seed_cnt_nxt = seed_cnt;
    good_cnt_nxt = good_cnt;
    bad_cnt_nxt  = bad_cnt;
    if (in_valid) begin
      case (state)
        SEED: begin
          if (seed_cnt == 3'd7) begin
            state_nxt    = TRACK;
            seed_cnt_nxt = '0;
            good_cnt_nxt = '0;
          end else begin
            seed_cnt_nxt = seed_cnt + 3'd1;
          end
        end
        TRACK: begin
          if (!match) begin
            state_nxt    = SEED;
            seed_cnt_nxt = '0;
          end else if (good_cnt + 5'd1 == LOCK_N) begin
            good_cnt_nxt = '0;
            // An all-zero history would predict zeros forever; refuse to lock on it
            if (h_zero) begin
              state_nxt    = SEED;
              seed_cnt_nxt = '0;
            end else begin
              state_nxt   = LOCKED;
              bad_cnt_nxt = '0;
            end
          end else begin
            good_cnt_nxt = good_cnt + 5'd1;
          end
        end
        LOCKED: begin
          if (!match)              bad_cnt_nxt = bad_cnt + 5'd1;
          else if (bad_cnt != '0)  bad_cnt_nxt = bad_cnt - 5'd1;
          if ((!match && (bad_cnt + 5'd1 == UNLOCK_N)) || h_zero) begin
            state_nxt    = SEED;
            seed_cnt_nxt = '0;
          end
        end
        default: begin
          state_nxt    = SEED;
          seed_cnt_nxt = '0;
        end
      endcase
    end
  end

  // Output decode: lock flag follows the next state, errors only while locked
  always_comb begin
    locked_nxt  = (state_nxt == LOCKED);
    err_nxt     = in_valid && (state == LOCKED) && !match;
    err_cnt_nxt = err_cnt;
    if (clr_cnt)
      err_cnt_nxt = '0;
    else if (err_nxt && (err_cnt != '1))
      err_cnt_nxt = err_cnt + ERR_W'(1);
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked  <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      locked  <= locked_nxt;
      err     <= err_nxt;
      err_cnt <= err_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_prbs8_checker.sv
// Testbench for prbs8_checker: two instances (ERR_W=16 and ERR_W=4) share one
// stimulus stream and are compared every cycle against a bit-history model,
// with directed literal checks at the points of interest.
module tb_prbs8_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        locked_a, err_a, locked_b, err_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  always #5 clk = ~clk;

  prbs8_checker #(.LOCK_CNT(16), .UNLOCK_CNT(8), .ERR_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
    .clr_cnt(clr_cnt), .locked(locked_a), .err(err_a), .err_cnt(cnt_a)
  );

  prbs8_checker #(.LOCK_CNT(16), .UNLOCK_CNT(8), .ERR_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
    .clr_cnt(clr_cnt), .locked(locked_b), .err(err_b), .err_cnt(cnt_b)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_SEED = 0, M_TRACK = 1, M_LOCKED = 2;
  bit hist[$];          // received bits, oldest first, always 8 entries
  int mode, seen, good, bad;
  bit m_locked, m_err;
  int m_cnt_a, m_cnt_b;
  bit predicted, mism, zero;

  task automatic model_reset();
    hist.delete();
    repeat (8) hist.push_back(1'b0);
    mode = M_SEED; seen = 0; good = 0; bad = 0;
    m_locked = 0; m_err = 0; m_cnt_a = 0; m_cnt_b = 0;
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      m_err = 0;
      if (in_valid) begin
        // bits 2, 3, 4 and 8 positions back in the received stream
        predicted = hist[6] ^ hist[5] ^ hist[4] ^ hist[0];
        mism = (in_bit != predicted);
        hist.push_back(in_bit);
        void'(hist.pop_front());
        zero = 1;
        foreach (hist[i]) if (hist[i]) zero = 0;
        if (mode == M_SEED) begin
          seen++;
          if (seen == 8) begin mode = M_TRACK; good = 0; end
        end else if (mode == M_TRACK) begin
          if (mism) begin
            mode = M_SEED; seen = 0;
          end else begin
            good++;
            if (good == 16) begin
              if (zero) begin mode = M_SEED; seen = 0; end
              else begin mode = M_LOCKED; bad = 0; end
            end
          end
        end else begin
          if (mism) begin m_err = 1; bad++; end
          else if (bad > 0) bad--;
          if (bad == 8 || zero) begin mode = M_SEED; seen = 0; end
        end
      end
      if (clr_cnt) begin
        m_cnt_a = 0; m_cnt_b = 0;
      end else if (m_err) begin
        if (m_cnt_a < 65535) m_cnt_a++;
        if (m_cnt_b < 15)    m_cnt_b++;
      end
      m_locked = (mode == M_LOCKED);
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("locked_a", locked_a, m_locked);
      chk("err_a", err_a, m_err);
      chk("cnt_a", cnt_a, m_cnt_a);
      chk("locked_b", locked_b, m_locked);
      chk("err_b", err_b, m_err);
      chk("cnt_b", cnt_b, m_cnt_b);
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] g;        // transmitter generator state
  logic [7:0] tx;       // last 8 accepted bits as sent
  int errs_seen;

  task automatic gen(output bit b);
    b = g[1] ^ g[2] ^ g[3] ^ g[7];
    g = {g[6:0], b};
  endtask

  task automatic send(input bit v, input bit b, input bit c);
    @(negedge clk);
    in_valid = v; in_bit = b; clr_cnt = c;
    @(posedge clk);
    #1;
    if (v) tx = {tx[6:0], b};
    if (err_a) errs_seen++;
    clr_cnt = 1'b0;
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_locked", locked_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_cnt_b", cnt_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  bit b;
  int nv;
  bit ever_locked, ever_err;

  initial begin
    model_reset();
    g = 8'b10111101;
    tx = '0;
    #23;
    chk("reset_locked", locked_a, 0);
    chk("reset_err", err_a, 0);
    chk("reset_cnt", cnt_a, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean stream: lock after 24 valid bits, no errors over 1000 bits
    errs_seen = 0;
    for (int i = 1; i <= 1000; i++) begin
      gen(b);
      send(1'b1, b, 1'b0);
      if (i == 23) chk("lock_before_24", locked_a, 0);
      if (i == 24) chk("lock_at_24", locked_a, 1);
    end
    chk("clean_errs", errs_seen, 0);
    chk("clean_cnt", cnt_a, 0);

    // Single flipped bit: five error pulses, stays locked
    errs_seen = 0;
    for (int i = 0; i < 20; i++) begin
      gen(b);
      send(1'b1, (i == 0) ? ~b : b, 1'b0);
    end
    chk("flip_errs", errs_seen, 5);
    chk("flip_cnt", cnt_a, 5);
    chk("flip_locked", locked_a, 1);

    // Eight bits each opposite to the checker's prediction: unlock on the 8th
    for (int i = 1; i <= 8; i++) begin
      send(1'b1, ~(tx[1] ^ tx[2] ^ tx[3] ^ tx[7]), 1'b0);
      if (i == 7) chk("unlock_before_8", locked_a, 1);
      if (i == 8) chk("unlock_at_8", locked_a, 0);
    end
    chk("unlock_cnt", cnt_a, 13);
    for (int i = 1; i <= 24; i++) begin
      gen(b);
      send(1'b1, b, 1'b0);
      if (i == 23) chk("relock_before_24", locked_a, 0);
      if (i == 24) chk("relock_at_24", locked_a, 1);
    end

    // Reset while locked, then relock with gaps in in_valid
    chk("pre_rst_locked", locked_a, 1);
    reset_pulse();
    nv = 0;
    for (int it = 0; it < 400 && nv < 24; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        gen(b);
        send(1'b1, b, 1'b0);
        nv++;
      end else begin
        send(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end
      chk("gap_lock", locked_a, (nv >= 24) ? 1 : 0);
    end
    chk("gap_valid_budget", nv, 24);
    chk("gap_cnt", cnt_a, 0);

    // Twenty errors: 16-bit counter counts, 4-bit counter saturates
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < 20; i++) begin
        gen(b);
        send(1'b1, (i == 0) ? ~b : b, 1'b0);
      end
    end
    chk("sat_cnt_b", cnt_b, 15);
    chk("sat_cnt_a", cnt_a, 20);
    chk("sat_locked", locked_a, 1);

    // Clear coincident with an error: clear wins, pulse still seen
    gen(b);
    send(1'b1, ~b, 1'b1);
    chk("clr_err", err_a, 1);
    chk("clr_cnt_a", cnt_a, 0);
    chk("clr_cnt_b", cnt_b, 0);
    for (int i = 1; i < 20; i++) begin
      gen(b);
      send(1'b1, b, 1'b0);
    end
    chk("post_clr_cnt", cnt_a, 4);

    // Constant zero stream never locks and never errors
    chk("pre_zero_locked", locked_a, 1);
    reset_pulse();
    ever_locked = 0; ever_err = 0;
    for (int i = 0; i < 100; i++) begin
      send(1'b1, 1'b0, 1'b0);
      if (locked_a) ever_locked = 1;
      if (err_a) ever_err = 1;
    end
    chk("zero_locked", ever_locked, 0);
    chk("zero_err", ever_err, 0);

    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
